// File: rtl/redux_stream.sv
// Streaming 2x2 image reducer (min/max/avg/decimate) with an internal line buffer.
// Optional `REDUX_FRAME_SYNC_EN adds in_sof framing and a sticky sync_err flag.
module redux_stream #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int PIX_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_data,
`ifdef REDUX_FRAME_SYNC_EN
    input  logic             in_sof,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_eol,
    output logic             out_eof,
`ifdef REDUX_FRAME_SYNC_EN
    output logic             sync_err,
`endif
    output logic             frame_done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int HW = WIDTH / 2;
    localparam int AW = (HW > 1) ? $clog2(HW) : 1;
    localparam int PW = PIX_W + 1;
    localparam int SW = PIX_W + 2;

    localparam logic [1:0] M_MIN = 2'd0;
    localparam logic [1:0] M_MAX = 2'd1;
    localparam logic [1:0] M_AVG = 2'd2;
    localparam logic [1:0] M_DEC = 2'd3;

    logic [CW-1:0]    col_q, col_d, eff_col;
    logic [RW-1:0]    row_q, row_d, eff_row;
    logic [1:0]       mode_q, mode_d;
    logic [PIX_W-1:0] h_q, h_d;
    logic             ov_q, ov_d;
    logic [PIX_W-1:0] od_q, od_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;
    logic [PW-1:0]    lb_q [HW];

    logic             acc, last_col, last_row;
    logic             load, lb_we;
    logic [AW-1:0]    lb_idx;
    logic [PW-1:0]    p, top;
    logic [SW-1:0]    sum;
    logic [PIX_W-1:0] res;

    assign in_ready   = !ov_q || out_ready;
    assign acc        = in_valid && in_ready;
    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_eol    = eol_q;
    assign out_eof    = eof_q;
    assign frame_done = ov_q && out_ready && eof_q;

    // A start-of-frame beat is treated as position (0,0) regardless of the counters.
`ifdef REDUX_FRAME_SYNC_EN
    logic serr_q, serr_d;
    assign eff_col  = in_sof ? '0 : col_q;
    assign eff_row  = in_sof ? '0 : row_q;
    assign serr_d   = serr_q
                    | (acc && in_sof && (col_q != '0 || row_q != '0));
    assign sync_err = serr_q;
`else
    assign eff_col = col_q;
    assign eff_row = row_q;
`endif

    assign last_col = eff_col == CW'(WIDTH - 1);
    assign last_row = eff_row == RW'(HEIGHT - 1);
    assign lb_idx   = AW'(eff_col >> 1);
    assign load     = acc && eff_col[0] && eff_row[0];
    assign lb_we    = acc && eff_col[0] && !eff_row[0];
    assign top      = lb_q[lb_idx];
    assign sum      = SW'(top) + SW'(p) + SW'(2);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        mode_d = mode_q;
        h_d    = h_q;
        if (acc) begin
            col_d = last_col ? '0 : eff_col + CW'(1);
            if (last_col)
                row_d = last_row ? '0 : eff_row + RW'(1);
            else
                row_d = eff_row;
            if (eff_col == '0 && eff_row == '0)
                mode_d = mode;
            if (!eff_col[0])
                h_d = in_data;
        end
    end

    always_comb begin
        p = '0;
        unique case (mode_q)
            M_MIN:   p = {1'b0, (h_q < in_data) ? h_q : in_data};
            M_MAX:   p = {1'b0, (h_q > in_data) ? h_q : in_data};
            M_AVG:   p = {1'b0, h_q} + {1'b0, in_data};
            M_DEC:   p = {1'b0, h_q};
            default: p = '0;
        endcase
    end

    always_comb begin
        res = '0;
        unique case (mode_q)
            M_MIN:   res = PIX_W'((top < p) ? top : p);
            M_MAX:   res = PIX_W'((top > p) ? top : p);
            M_AVG:   res = PIX_W'(sum >> 2);
            M_DEC:   res = PIX_W'(top);
            default: res = '0;
        endcase
    end

    // A fresh result may load in the same cycle the held one is taken.
    always_comb begin
        ov_d  = ov_q;
        od_d  = od_q;
        eol_d = eol_q;
        eof_d = eof_q;
        if (load) begin
            ov_d  = 1'b1;
            od_d  = res;
            eol_d = last_col;
            eof_d = last_col && last_row;
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= '0;
            h_q    <= '0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            eol_q  <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            mode_q <= mode_d;
            h_q    <= h_d;
            ov_q   <= ov_d;
            od_q   <= od_d;
            eol_q  <= eol_d;
            eof_q  <= eof_d;
        end
    end

`ifdef REDUX_FRAME_SYNC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            serr_q <= 1'b0;
        else
            serr_q <= serr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (lb_we)
            lb_q[lb_idx] <= p;
    end
endmodule

// File: tb/tb_redux_stream.sv
// Randomised and directed bench for redux_stream on a 4x4 frame,
// scored against a per-block arithmetic reference model.
module tb_redux_stream;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_data;
    logic          out_eol;
    logic          out_eof;
    logic          frame_done;
`ifdef REDUX_FRAME_SYNC_EN
    logic          in_sof;
    logic          sync_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int mon_cnt  = 0;
    int fd_cnt   = 0;
    int eof_exp  = 0;
    bit rnd      = 0;
    bit rnd_bp   = 0;

    logic [9:0]    expq [$];
    logic [PW-1:0] fr [W*H];
    logic [PW-1:0] sdata [64];
    logic [1:0]    smode [64];
    bit            ssof [64];

    always #5 clk = ~clk;

    redux_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
`ifdef REDUX_FRAME_SYNC_EN
        .in_sof     (in_sof),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
`ifdef REDUX_FRAME_SYNC_EN
        .sync_err   (sync_err),
`endif
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid && out_ready) begin
            mon_cnt++;
            if (expq.size() == 0) begin
                chk("out_unexpected", 32'd1, 32'd0);
            end else begin
                logic [9:0] e;
                e = expq.pop_front();
                chk("out", {22'd0, out_eof, out_eol, out_data}, {22'd0, e});
            end
        end
        if (rst_n === 1'b1 && frame_done)
            fd_cnt++;
    end

    task automatic push(input int v, input bit eol, input bit eof);
        logic [7:0] b;
        b = 8'(v);
        expq.push_back({eof, eol, b});
        if (eof)
            eof_exp++;
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        push(a, 0, 0);
        push(b, 1, 0);
        push(c, 0, 0);
        push(d, 1, 1);
    endtask

    // Reference: reduce each 2x2 block of fr with plain arithmetic.
    task automatic push_model(input int nblk, input logic [1:0] m);
        for (int b = 0; b < nblk; b++) begin
            int br, bc, px[4], v;
            br = b / (W / 2);
            bc = b % (W / 2);
            px[0] = int'(fr[(2*br)*W + 2*bc]);
            px[1] = int'(fr[(2*br)*W + 2*bc + 1]);
            px[2] = int'(fr[(2*br+1)*W + 2*bc]);
            px[3] = int'(fr[(2*br+1)*W + 2*bc + 1]);
            v = px[0];
            case (m)
                2'd0: for (int k = 1; k < 4; k++) if (px[k] < v) v = px[k];
                2'd1: for (int k = 1; k < 4; k++) if (px[k] > v) v = px[k];
                2'd2: v = (px[0] + px[1] + px[2] + px[3] + 2) / 4;
                default: v = px[0];
            endcase
            push(v, bc == W/2 - 1, bc == W/2 - 1 && br == H/2 - 1);
        end
    endtask

    task automatic set_row(input int r, input int a, input int b,
                           input int c, input int d);
        fr[r*W]     = 8'(a);
        fr[r*W + 1] = 8'(b);
        fr[r*W + 2] = 8'(c);
        fr[r*W + 3] = 8'(d);
    endtask

    task automatic test_frame();
        set_row(0, 10, 20, 30, 40);
        set_row(1, 5, 25, 35, 1);
        set_row(2, 7, 7, 7, 7);
        set_row(3, 8, 9, 2, 3);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < W*H; i++) begin
            case ($urandom_range(5))
                0: fr[i] = 8'd0;
                1: fr[i] = 8'd255;
                default: fr[i] = 8'($urandom_range(255));
            endcase
        end
    endtask

    task automatic to_stream(input int base, input int first, input int n,
                             input logic [1:0] m);
        for (int i = 0; i < n; i++) begin
            sdata[base + i] = fr[first + i];
            smode[base + i] = m;
            ssof[base + i]  = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_bp)
            out_ready = 1'($urandom_range(1));
    endtask

    task automatic send_stream(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bit acc;
            if (rnd) begin
                while ($urandom_range(3) == 0) begin
                    in_valid = 1'b0;
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = sdata[i];
            mode     = smode[i];
`ifdef REDUX_FRAME_SYNC_EN
            in_sof   = ssof[i];
`endif
            acc = 0;
            for (int k = 0; k < 200 && !acc; k++) begin
                @(negedge clk);
                acc = in_ready;
                step();
            end
            if (!acc)
                chk("accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
`ifdef REDUX_FRAME_SYNC_EN
        in_sof   = 1'b0;
`endif
    endtask

    task automatic drain();
        rnd_bp    = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 200 && expq.size() != 0; k++)
            step();
        step();
        chk("drain", expq.size(), 32'd0);
    endtask

    task automatic run_directed(input logic [1:0] m);
        to_stream(0, 0, W*H, m);
        send_stream(0, W*H - 1);
        drain();
    endtask

    task automatic chk_zero_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_flags"}, {30'd0, out_eol, out_eof}, 32'd0);
        chk({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        logic [1:0] m0;
        int         c0;
        rst_n     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef REDUX_FRAME_SYNC_EN
        in_sof    = 1'b0;
`endif
        chk_zero_outputs("reset");
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        test_frame();
        push4(5, 1, 7, 2);
        run_directed(2'd0);
        chk("frame_done_once", fd_cnt, 32'd1);
        push4(25, 40, 9, 7);
        run_directed(2'd1);
        push4(15, 27, 8, 5);
        run_directed(2'd2);
        push4(10, 30, 7, 7);
        run_directed(2'd3);

        set_row(0, 0, 0, 1, 1);
        set_row(1, 0, 1, 1, 0);
        set_row(2, 255, 255, 255, 255);
        set_row(3, 255, 255, 255, 255);
        push4(0, 1, 255, 255);
        run_directed(2'd2);

        // Mode changes mid-frame take effect from the next frame only.
        test_frame();
        to_stream(0, 0, W*H, 2'd0);
        for (int i = W; i < W*H; i++)
            smode[i] = 2'd1;
        push4(5, 1, 7, 2);
        send_stream(0, W*H - 1);
        push4(25, 40, 9, 7);
        run_directed(2'd1);

        // Output stall holds data and blocks input.
        test_frame();
        to_stream(0, 0, W*H, 2'd0);
        push4(5, 1, 7, 2);
        c0 = mon_cnt;
        out_ready = 1'b0;
        send_stream(0, 5);
        in_valid = 1'b1;
        in_data  = sdata[6];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold", {22'd0, out_eof, out_eol, out_data}, 32'h005);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        send_stream(6, W*H - 1);
        drain();
        chk("bp_count", mon_cnt - c0, 32'd4);

        // Reset mid-row 1 with a result pending.
        out_ready = 1'b0;
        to_stream(0, 0, W*H, 2'd0);
        send_stream(0, 5);
        #3 rst_n = 1'b0;
        chk_zero_outputs("midrst");
        chk_zero_outputs("midrst2");
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        rand_frame();
        push_model(4, 2'd2);
        run_directed(2'd2);

        rnd    = 1;
        rnd_bp = 1;
        for (int f = 0; f < 30; f++) begin
            rand_frame();
            m0 = 2'($urandom_range(3));
            push_model(4, m0);
            to_stream(0, 0, W*H, m0);
            for (int i = 1; i < W*H; i++)
                smode[i] = 2'($urandom_range(3));
            rnd_bp = 1;
            send_stream(0, W*H - 1);
        end
        drain();
        rnd = 0;

`ifdef REDUX_FRAME_SYNC_EN
        chk("sync_err_idle", {31'd0, sync_err}, 32'd0);
        rand_frame();
        push_model(2, 2'd0);
        to_stream(0, 0, 9, 2'd0);
        rand_frame();
        push_model(4, 2'd1);
        to_stream(9, 0, W*H, 2'd1);
        ssof[9] = 1'b1;
        send_stream(0, 9 + W*H - 1);
        drain();
        chk("sync_err_set", {31'd0, sync_err}, 32'd1);
`endif

        chk("frame_done_total", fd_cnt, eof_exp);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/redux_stream.md
Name: redux_stream

Overview:
- Streaming 2x2 image reducer. Accepts raster-order pixels over a valid/ready handshake and emits one reduced pixel per 2x2 block.
- Generalises the combinational 2x2 minimum reducer: parametrised frame size and pixel width, selectable reduction mode, and an internal line buffer, so the upstream source no longer needs a frame memory.
- Sits between the pixel source and the downscaled-frame sink in the image-reduction pipeline.

Parameters:
- WIDTH, 160, input frame width in pixels; even, >= 2
- HEIGHT, 120, input frame height in pixels; even, >= 2
- PIX_W, 8, bits per pixel

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  reduction mode: 0 min, 1 max, 2 rounded average, 3 decimate (top-left pixel)
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_data  in  PIX_W  input pixel, raster order, row-major
- out_valid  out  1  reduced pixel valid
- out_ready  in  1  sink ready
- out_data  out  PIX_W  reduced pixel
- out_eol  out  1  qualifies out_data as last pixel of an output row
- out_eof  out  1  qualifies out_data as last pixel of the output frame
- frame_done  out  1  one-cycle pulse when the out_eof beat is accepted

Behaviour:
- Reset is asynchronous, active-low, and may occur at any cycle. While rst_n = 0:
  - out_valid, out_data, out_eol, out_eof and frame_done are 0.
  - The column counter, row counter, horizontal register and latched mode are 0.
  - Line-buffer contents are not reset.
- in_ready = !out_valid || out_ready, combinational.
- Column counter col runs 0..WIDTH-1 and row counter row runs 0..HEIGHT-1. Both advance only on accepted input beats. At col = WIDTH-1, col wraps to 0 and row increments. At the last pixel of the frame, row wraps to 0.
- Mode is latched when the beat at row 0, col 0 is accepted, and is held for the whole frame. Changes to mode mid-frame are ignored.
- Horizontal stage:
  - On even col, store the pixel in h_reg.
  - On odd col, form partial p from h_reg and in_data:
    - min/max: p = min/max of the two pixels, zero-extended.
    - avg: p = h_reg + in_data, PIX_W+1 bits.
    - decimate: p = h_reg.
- Line buffer: WIDTH/2 entries, each PIX_W+1 bits, indexed by col>>1.
  - Even row: write p at odd col.
  - Odd row: read the entry at odd col and combine it with p:
    - min/max: min/max of the two.
    - avg: (top + p + 2) >> 2, computed with PIX_W+2-bit intermediates; result fits PIX_W.
    - decimate: top entry.
- Output register:
  - The combined result loads on the cycle the odd-row/odd-col beat is accepted; out_valid rises on the next clock (latency 1).
  - out_eol = 1 when the source col = WIDTH-1.
  - out_eof = 1 when additionally row = HEIGHT-1.
- Output holds (data and flags stable) while out_valid && !out_ready. out_valid clears on acceptance unless a new result loads in the same cycle.
- Simultaneous output acceptance and new input beat: the output is accepted, the new result loads, and out_valid stays 1. This gives full throughput of 1 pixel/cycle in, 1 output per 4 input beats.
- in_ready is also low during output stall on even rows. This is intentional, for a simple flow-control rule.
- Output count per frame is exactly (WIDTH/2)*(HEIGHT/2).

Optional Feature:
- REDUX_FRAME_SYNC_EN adds input port in_sof (1 bit, qualified by in_valid && in_ready).
- With the macro defined:
  - An accepted beat with in_sof = 1 forces col = 0, row = 0 for that beat and latches mode. Any partial frame is abandoned with no output.
  - An in_sof beat at a position other than row 0, col 0 sets sticky status bit sync_err (extra output port), cleared only by reset.
- Without the macro: no in_sof or sync_err ports; counters free-run on beat count alone.

Test Plan:
- WIDTH=4, HEIGHT=4, mode=0. Rows 10 20 30 40 / 5 25 35 1 / 7 7 7 7 / 8 9 2 3, out_ready=1. Outputs in order:
  - 5 (eol=0), 1 (eol=1), 7, 2 (eol=1, eof=1)
  - frame_done pulses once.
- Same frame, mode=1: outputs 25, 40, 9, 7. Mode=2: outputs 15, 27, 8, 5. Mode=3: outputs 10, 30, 7, 7.
- Avg full-range, PIX_W=8: all pixels 255 gives 255; pixels 0, 0, 0, 1 give 0; pixels 1, 1, 1, 0 give 1. No overflow.
- Backpressure: out_ready low for 5 cycles while out_valid=1. Required: out_data and flags stable, and in_ready=0 throughout. After release, no output is lost or duplicated; output count = 4.
- Mode toggled from 0 to 1 at row 1 of the frame: the whole frame is reduced as min. The next frame starts as max.
- Reset asserted mid-row 1, then a fresh frame is sent:
  - All outputs are 0 during reset.
  - The first output after reset corresponds to the new frame's block (0,0) only.
- With REDUX_FRAME_SYNC_EN: in_sof asserted at row 2, col 1. Required: the frame restarts at that beat, sync_err=1, and the following complete frame produces the correct 4 outputs.
